// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
//   XLEN, NREGS, AW : default data width, register count and address width
//   xlen_t          : one register's data word
//   reg_addr_t      : architectural register index
//   cnt_op_e        : per-cycle action on the busy-register counter
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [AW-1:0]   reg_addr_t;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_CLR
  } cnt_op_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for the register file.
//   clk, rst_n          : clock, async active-low reset
//   iss_valid, iss_rd   : reserve destination register (fires when iss_ready)
//   iss_ready           : reservation can be accepted this cycle
//   wb_valid, wb_rd     : write-back releases wb_rd
//   flush               : drop all reservations
//   busy_vec, busy_cnt  : registered busy bits and number of busy registers
// x0 is never busy; a reservation of x0 is accepted and ignored.
module regfile_scoreboard #(
  parameter int NREGS = regfile_pkg::NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ready,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec,
  output logic [AW:0]      busy_cnt
);

  import regfile_pkg::*;

  typedef logic [AW:0] cnt_t;

  logic [NREGS-1:0] busy_d, busy_q;
  cnt_t             busy_cnt_d, busy_cnt_q;
  cnt_op_e          cnt_op;
  logic             fire;
  logic             inc;
  logic             dec;

  // A busy destination may be re-reserved only in the cycle it is released,
  // which blocks WAW hazards without stalling back-to-back writers.
  assign iss_ready = !busy_q[iss_rd] || (wb_valid && (wb_rd == iss_rd)) ||
                     (iss_rd == '0);

  assign fire = iss_valid && iss_ready && (iss_rd != '0);

  // Count moves only on real transitions: reserving a free register, or
  // releasing a busy one that is not simultaneously re-reserved.
  assign inc = fire && !busy_q[iss_rd];
  assign dec = wb_valid && busy_q[wb_rd] && !(fire && (iss_rd == wb_rd));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    busy_d = busy_q;
    cnt_op = CNT_HOLD;
    if (flush) begin
      busy_d = '0;
      cnt_op = CNT_CLR;
    end else begin
      // Release first so a same-cycle reservation of the same register wins.
      if (wb_valid) busy_d[wb_rd] = 1'b0;
      if (fire)     busy_d[iss_rd] = 1'b1;
      if (inc && !dec)      cnt_op = CNT_INC;
      else if (dec && !inc) cnt_op = CNT_DEC;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    case (cnt_op)
      CNT_INC:  busy_cnt_d = busy_cnt_q + cnt_t'(1);
      CNT_DEC:  busy_cnt_d = busy_cnt_q - cnt_t'(1);
      CNT_CLR:  busy_cnt_d = '0;
      default:  busy_cnt_d = busy_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one write-back
// port, optional write-to-read bypass and a per-register scoreboard.
//   clk, rst_n           : clock, async active-low reset
//   rd_addr/rd_data      : read port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   rd_ready             : operand of port i is valid this cycle
//   iss_valid/iss_rd     : reserve destination; iss_ready accepts
//   wb_valid/wb_rd/wb_data : write-back data and release
//   flush                : clear all reservations, data untouched
//   busy_vec, busy_cnt   : scoreboard state
module regfile_sb #(
  parameter int XLEN   = regfile_pkg::XLEN,
  parameter int NREGS  = regfile_pkg::NREGS,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_ready,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic [NREGS-1:0]  busy_vec,
  output logic [AW:0]       busy_cnt
);

  import regfile_pkg::*;

  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] regs_q [NREGS];
  logic            fwd_en;

  assign fwd_en = (BYPASS != 0) && wb_valid;

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .busy_vec  (busy_vec),
    .busy_cnt  (busy_cnt)
  );

  // x0 is never written, so it keeps its reset value of zero forever.
  always_comb begin
    regs_d = regs_q;
    if (wb_valid && (wb_rd != '0)) regs_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the storage array is reset on purpose: architectural state must
    // read zero straight after reset, which costs a reset on every bit.
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = rd_addr[i*AW +: AW];
    assign hit  = fwd_en && (wb_rd == addr);

    // Forwarded data must never overwrite the hard-wired zero of x0.
    assign rd_data[i*XLEN +: XLEN] = (hit && (addr != '0)) ? wb_data : regs_q[addr];
    assign rd_ready[i]             = !busy_vec[addr] || hit;
  end

endmodule
